// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the keypad / register-bank / ALU datapath: LOAD writes keypad nibbles
// into a register, OP runs the ALU on two registers. Define KEY_TIMEOUT_EN to abort idle LOADs.
module alu_seq_ctrl #(
  parameter int          KEY_DIGITS  = 2,
  parameter logic [23:0] KEY_TIMEOUT = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_kind,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_src_a,
  input  logic [1:0] cmd_src_b,
  input  logic [1:0] cmd_dst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [1:0] rf_addr_a,
  output logic [1:0] rf_addr_b,
  output logic [1:0] rf_addr_wr,
  output logic [7:0] rf_wdata,
  output logic       rf_we,
  output logic [1:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] result,
  output logic       flag_zero,
  output logic       flag_carry,
  output logic [2:0] dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both high;
  // cmd_ready is low for the whole command, and cmd_valid seen while busy is dropped, never queued.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEY  = 3'd1,
    S_KWR  = 3'd2,
    S_RD   = 3'd3,
    S_EX   = 3'd4,
    S_WB   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [1:0] LAST_DIGIT = 2'(KEY_DIGITS - 1);

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] src_a_q, src_a_d;
  logic [1:0] src_b_q, src_b_d;
  logic [1:0] dst_q, dst_d;
  logic [1:0] digit_q, digit_d;
  logic [7:0] val_q, val_d;
  logic [7:0] val_shift;
  logic [1:0] rf_addr_wr_q, rf_addr_wr_d;
  logic [7:0] rf_wdata_q, rf_wdata_d;
  logic [7:0] result_q, result_d;
  logic       zero_q, zero_d;
  logic       carry_q, carry_d;
`ifdef KEY_TIMEOUT_EN
  logic [23:0] tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  assign val_shift = {val_q[3:0], key_code};

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    dst_d        = dst_q;
    digit_d      = digit_q;
    val_d        = val_q;
    rf_addr_wr_d = rf_addr_wr_q;
    rf_wdata_d   = rf_wdata_q;
    result_d     = result_q;
    zero_d       = zero_q;
    carry_d      = carry_q;
`ifdef KEY_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          src_a_d = cmd_src_a;
          src_b_d = cmd_src_b;
          dst_d   = cmd_dst;
          digit_d = 2'd0;
          val_d   = 8'h00;
`ifdef KEY_TIMEOUT_EN
          tmo_d   = 24'd0;
          err_d   = 1'b0;
`endif
          state_d = cmd_kind ? S_RD : S_KEY;
        end
      end
      S_KEY: begin
        if (key_valid) begin
          val_d   = val_shift;
          digit_d = digit_q + 2'd1;
`ifdef KEY_TIMEOUT_EN
          tmo_d   = 24'd0;
`endif
          // Write port registers are loaded on entry so they are valid during KWR and hold afterwards.
          if (digit_q == LAST_DIGIT) begin
            rf_addr_wr_d = dst_q;
            rf_wdata_d   = val_shift;
            state_d      = S_KWR;
          end
`ifdef KEY_TIMEOUT_EN
        end else if (tmo_q == KEY_TIMEOUT - 24'd1) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 24'd1;
`endif
        end
      end
      S_KWR: begin
        result_d = val_q;
        state_d  = S_DONE;
      end
      S_RD: state_d = S_EX;
      S_EX: begin
        result_d     = alu_out;
        zero_d       = alu_zero;
        carry_d      = alu_carry;
        rf_addr_wr_d = dst_q;
        rf_wdata_d   = alu_out;
        state_d      = S_WB;
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 2'd0;
      src_a_q      <= 2'd0;
      src_b_q      <= 2'd0;
      dst_q        <= 2'd0;
      digit_q      <= 2'd0;
      val_q        <= 8'h00;
      rf_addr_wr_q <= 2'd0;
      rf_wdata_q   <= 8'h00;
      result_q     <= 8'h00;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      dst_q        <= dst_d;
      digit_q      <= digit_d;
      val_q        <= val_d;
      rf_addr_wr_q <= rf_addr_wr_d;
      rf_wdata_q   <= rf_wdata_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      carry_q      <= carry_d;
    end
  end

`ifdef KEY_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 24'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Control strobes decode straight from state so reset kills rf_we without waiting for a clock.
  assign busy       = (state_q != S_IDLE);
  assign cmd_ready  = (state_q == S_IDLE);
  assign rf_we      = (state_q == S_KWR) || (state_q == S_WB);
  assign done       = (state_q == S_DONE);
  assign rf_addr_a  = src_a_q;
  assign rf_addr_b  = src_b_q;
  assign alu_sel    = op_q;
  assign rf_addr_wr = rf_addr_wr_q;
  assign rf_wdata   = rf_wdata_q;
  assign result     = result_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a register bank + ALU surround, randomized commands, and a scoreboard
// fed by an abstract model of the register file and flags.
module tb_alu_seq_ctrl;

  localparam int          KEY_DIGITS  = 2;
  localparam logic [23:0] KEY_TIMEOUT = 24'd16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_kind = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [1:0] cmd_src_a = 2'd0;
  logic [1:0] cmd_src_b = 2'd0;
  logic [1:0] cmd_dst = 2'd0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [1:0] rf_addr_a, rf_addr_b, rf_addr_wr;
  logic [7:0] rf_wdata;
  logic       rf_we;
  logic [1:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry, alu_zero;
  logic       busy, done, err;
  logic [7:0] result;
  logic       flag_zero, flag_carry;
  logic [2:0] dbg_state;

  alu_seq_ctrl #(.KEY_DIGITS(KEY_DIGITS), .KEY_TIMEOUT(KEY_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .key_valid(key_valid), .key_code(key_code),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_addr_wr(rf_addr_wr),
    .rf_wdata(rf_wdata), .rf_we(rf_we), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .busy(busy), .done(done), .err(err), .result(result),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- register bank + ALU surround ----------------
  function automatic logic [8:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  logic [7:0] bank [4];
  logic [8:0] alu_res;
  always @(posedge clk) if (rf_we) bank[rf_addr_wr] <= rf_wdata;
  always_comb alu_res = alu_fn(alu_sel, bank[rf_addr_a], bank[rf_addr_b]);
  assign alu_out   = alu_res[7:0];
  assign alu_carry = alu_res[8];
  assign alu_zero  = (alu_res[7:0] == 8'h00);

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
    logic [31:0] cyc;
  } wr_exp_t;

  typedef struct packed {
    logic        err;
    logic [7:0]  result;
    logic        zero;
    logic        carry;
    logic [7:0]  wdata;
    logic [31:0] cyc;
  } done_exp_t;

  wr_exp_t   wr_q[$];
  done_exp_t done_q[$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: architectural register contents and status, updated per command.
  logic [7:0] model_rf [4];
  logic [7:0] m_result = 8'h00;
  logic       m_zero = 1'b0;
  logic       m_carry = 1'b0;
  logic [7:0] m_wdata = 8'h00;

  // Monitor: pops expectations whenever the DUT writes the bank or signals done.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
    end else begin
      if (prev_done) chk("ready_after_done", {31'd0, cmd_ready}, 32'd1);
      if (rf_we) begin
        if (wr_q.size() == 0) fail("unexpected_rf_we");
        else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          chk("wr_addr", {30'd0, rf_addr_wr}, {30'd0, e.addr});
          chk("wr_data", {24'd0, rf_wdata}, {24'd0, e.data});
          chk("wr_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail("unexpected_done");
        else begin
          done_exp_t d;
          d = done_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_err", {31'd0, err}, {31'd0, d.err});
          chk("done_result", {24'd0, result}, {24'd0, d.result});
          chk("done_flags", {30'd0, flag_zero, flag_carry}, {30'd0, d.zero, d.carry});
          chk("wdata_hold", {24'd0, rf_wdata}, {24'd0, d.wdata});
          chk("busy_in_done", {31'd0, busy}, 32'd1);
        end
      end
      prev_done <= done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic kind, input logic [1:0] op, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] dst, input bit stray, output int acc);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_kind  = kind;
    cmd_op    = op;
    cmd_src_a = a;
    cmd_src_b = b;
    cmd_dst   = dst;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail("accept_timeout");
    acc = cyc;
    if (stray) begin
      key_valid = 1'b1;
      key_code  = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    key_valid = 1'b0;
    cmd_kind  = 1'($urandom_range(0, 1));
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_src_a = 2'($urandom_range(0, 3));
    cmd_src_b = 2'($urandom_range(0, 3));
    cmd_dst   = 2'($urandom_range(0, 3));
  endtask

  task automatic do_op(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] dst, input bit stray, output int acc);
    logic [8:0] r;
    issue(1'b1, op, a, b, dst, stray, acc);
    r = alu_fn(op, model_rf[a], model_rf[b]);
    model_rf[dst] = r[7:0];
    m_result = r[7:0];
    m_zero   = (r[7:0] == 8'h00);
    m_carry  = r[8];
    m_wdata  = r[7:0];
    wr_q.push_back('{addr: dst, data: r[7:0], cyc: 32'(acc + 3)});
    done_q.push_back('{err: 1'b0, result: m_result, zero: m_zero, carry: m_carry,
                       wdata: m_wdata, cyc: 32'(acc + 4)});
  endtask

  task automatic do_load(input logic [1:0] dst, input logic [3:0] hi, input logic [3:0] lo,
                         input bit stray);
    int acc;
    int kc;
    issue(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          dst, stray, acc);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    key_valid = 1'b1;
    key_code  = hi;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'($urandom_range(0, 15));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    key_valid = 1'b1;
    key_code  = lo;
    kc = cyc;
    model_rf[dst] = {hi, lo};
    m_result = {hi, lo};
    m_wdata  = {hi, lo};
    wr_q.push_back('{addr: dst, data: {hi, lo}, cyc: 32'(kc + 1)});
    done_q.push_back('{err: 1'b0, result: m_result, zero: m_zero, carry: m_carry,
                       wdata: m_wdata, cyc: 32'(kc + 2)});
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic stray_keys(input int n);
    repeat (n) begin
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'($urandom_range(0, 15));
      @(negedge clk);
      key_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0 || !cmd_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("drain_timeout");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, a1, a2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_flags", {30'd0, flag_zero, flag_carry}, 32'd0);
    chk("rst_wdata", {24'd0, rf_wdata}, 32'd0);
    rst_n = 1'b1;

    // Directed LOAD: keys A then 5 into r2.
    do_load(2'd2, 4'hA, 4'h5, 1'b0);
    wait_idle();
    chk("load_a5_result", {24'd0, result}, 32'h0000_00A5);

    // Fill the bank; stray keys in IDLE and in the acceptance cycle must not leak in.
    stray_keys(3);
    do_load(2'd0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
    do_load(2'd1, 4'h8, 4'h0, 1'b1);
    stray_keys(2);
    do_load(2'd2, 4'h8, 4'h0, 1'b0);
    do_load(2'd3, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
    wait_idle();

    // OP timing: 0x80 + 0x80 gives 0x00 with carry and zero set.
    do_op(2'd0, 2'd1, 2'd2, 2'd3, 1'b0, acc);
    wait_idle();
    chk("op_result", {24'd0, result}, 32'd0);
    chk("op_zero_carry", {30'd0, flag_zero, flag_carry}, 32'd3);

    // Chained OPs on r0, second cmd_valid held while the first is busy.
    do_op(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, a1);
    do_op(2'd0, 2'd0, 2'd0, 2'd0, 1'b1, a2);
    chk("chain_accept_gap", a2 - a1, 32'd5);
    do_op(2'd3, 2'd0, 2'd1, 2'd0, 1'b0, a1);
    do_op(2'd1, 2'd0, 2'd0, 2'd0, 1'b0, a2);
    chk("chain_accept_gap2", a2 - a1, 32'd5);
    wait_idle();

`ifdef KEY_TIMEOUT_EN
    // LOAD with no keys: abort after KEY_TIMEOUT cycles in KEY, nothing written.
    issue(1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0, acc);
    done_q.push_back('{err: 1'b1, result: m_result, zero: m_zero, carry: m_carry,
                       wdata: m_wdata, cyc: 32'(acc + 17)});
    wait_idle();
    chk("timeout_err_hold", {31'd0, err}, 32'd1);
`endif

    // Reset in the middle of a LOAD after one digit.
    issue(1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0, acc);
    key_valid = 1'b1;
    key_code  = 4'h3;
    @(negedge clk);
    key_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("mid_rst_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
    chk("mid_rst_result", {24'd0, result}, 32'd0);
    chk("mid_rst_flags_err", {29'd0, flag_zero, flag_carry, err}, 32'd0);
    m_result = 8'h00;
    m_zero   = 1'b0;
    m_carry  = 1'b0;
    m_wdata  = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    do_load(2'd1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
    wait_idle();

    // Randomized mix of commands.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc);
      else
        do_load(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) stray_keys($urandom_range(1, 2));
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    chk("final_result", {24'd0, result}, {24'd0, m_result});
    chk("queues_empty", 32'(wr_q.size() + done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
